// File: rtl/conv_pkg.sv
// Shared types and geometry helpers for the systolic convolution engine.
package conv_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_COMPUTE = 2'd2,
    S_OUTPUT  = 2'd3
  } state_e;

  // Bits needed for a counter that takes values 0..n-1.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int out_side(input int img, input int k);
    return img - k + 1;
  endfunction

  function automatic int n_out(input int img, input int k);
    return out_side(img, k) * out_side(img, k);
  endfunction

  function automatic int n_load(input int img, input int k);
    return img * img + k * k;
  endfunction

  // Derived constants for the default geometry (IMG=4, K=3).
  localparam int DEF_IMG = 4;
  localparam int DEF_K   = 3;
  localparam int OUT     = out_side(DEF_IMG, DEF_K);
  localparam int NOUT    = n_out(DEF_IMG, DEF_K);
  localparam int NLOAD   = n_load(DEF_IMG, DEF_K);
  localparam int LD_CW   = cnt_w(NLOAD);
  localparam int STEP_CW = cnt_w(DEF_K * DEF_K + 1);
  localparam int OIDX_CW = cnt_w(NOUT);

endpackage

// File: rtl/pe_mac.sv
// Output-stationary processing element: registered multiply, then accumulate.
module pe_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              mul_en_i,
  input  logic              acc_en_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [ACC_W-1:0]  acc_o
);

  logic [ACC_W-1:0] a_x, b_x, prod_q, acc_q;

  // Extend operands to accumulator width; the ACC_W-bit modular product is exact
  // in two's complement because the true product fits in 2*DATA_W bits.
  assign a_x = {{(ACC_W-DATA_W){(SIGNED != 0) & a_i[DATA_W-1]}}, a_i};
  assign b_x = {{(ACC_W-DATA_W){(SIGNED != 0) & b_i[DATA_W-1]}}, b_i};

  // Product stage feeds the accumulator one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_q <= '0;
      acc_q  <= '0;
    end else if (clr_i) begin
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      if (mul_en_i) prod_q <= a_x * b_x;
      if (acc_en_i) acc_q  <= acc_q + prod_q;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/systolic_conv_engine.sv
// Load image + kernel, run K*K broadcast steps over an OUT x OUT PE array,
// then stream converted results row-major with a valid/ready handshake.
module systolic_conv_engine
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG    = 4,
  parameter int K      = 3,
  parameter int ACC_W  = 2*DATA_W + $clog2(K*K),
  parameter int OUT_W  = 8,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sat_mode,
  output logic              busy,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_last,
  output logic              ovf,
  output logic              done
);

  localparam int OSZ  = out_side(IMG, K);
  localparam int NRES = n_out(IMG, K);
  localparam int NLD  = n_load(IMG, K);
  localparam int NPIX = IMG * IMG;
  localparam int KK   = K * K;
  localparam int LW   = cnt_w(NLD);
  localparam int SW   = cnt_w(KK + 1);
  localparam int OW   = cnt_w(NRES);
  localparam int KW   = cnt_w(K);
  localparam int PW   = cnt_w(NPIX);
  localparam int KIW  = cnt_w(KK);

  state_e state_q, state_d;

  logic [NPIX-1:0][DATA_W-1:0] img_q;
  logic [KK-1:0][DATA_W-1:0]   ker_q;
  logic [NRES-1:0][ACC_W-1:0]  accs;
  logic [LW-1:0]  ld_cnt_q, kofs;
  logic [SW-1:0]  step_q;
  logic [KW-1:0]  ky_q, kx_q;
  logic [OW-1:0]  oidx_q;
  logic [KIW-1:0] kidx;
  logic           mac_vld_q, sat_q, ovf_q, done_q;
  logic           start_acc, ld_fire, out_fire, mul_en, in_rng;
  logic [ACC_W-1:0] sel;
  logic [OUT_W-1:0] satv, conv;

  assign start_acc = (state_q == S_IDLE) && start;
  assign ld_fire   = ld_valid && ld_ready;
  assign out_fire  = out_valid && out_ready;
  assign mul_en    = (state_q == S_COMPUTE) && (step_q < SW'(KK));
  assign kofs      = ld_cnt_q - LW'(NPIX);
  assign kidx      = KIW'(int'(ky_q) * K + int'(kx_q));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next state and handshake outputs. COMPUTE holds one extra cycle so the
  // last product can drain through the PE multiply register.
  always_comb begin
    state_d   = state_q;
    busy      = 1'b1;
    ld_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid && ld_cnt_q == LW'(NLD-1)) state_d = S_COMPUTE;
      end
      S_COMPUTE: begin
        if (step_q == SW'(KK)) state_d = S_OUTPUT;
      end
      S_OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready && oidx_q == OW'(NRES-1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Buffers, step walk, output index and sticky flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      img_q     <= '0;
      ker_q     <= '0;
      ld_cnt_q  <= '0;
      step_q    <= '0;
      ky_q      <= '0;
      kx_q      <= '0;
      oidx_q    <= '0;
      mac_vld_q <= 1'b0;
      sat_q     <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      mac_vld_q <= mul_en;
      done_q    <= out_fire && out_last;
      if (start_acc) begin
        ld_cnt_q <= '0;
        step_q   <= '0;
        ky_q     <= '0;
        kx_q     <= '0;
        oidx_q   <= '0;
        sat_q    <= sat_mode;
        ovf_q    <= 1'b0;
      end
      if (ld_fire) begin
        if (ld_cnt_q < LW'(NPIX)) img_q[ld_cnt_q[PW-1:0]] <= ld_data;
        else                      ker_q[kofs[KIW-1:0]]    <= ld_data;
        ld_cnt_q <= ld_cnt_q + 1'b1;
      end
      if (state_q == S_COMPUTE && step_q < SW'(KK)) begin
        step_q <= step_q + 1'b1;
        // Kernel coordinates park on the last step so indices stay in range.
        if (step_q != SW'(KK-1)) begin
          if (kx_q == KW'(K-1)) begin
            kx_q <= '0;
            ky_q <= ky_q + 1'b1;
          end else begin
            kx_q <= kx_q + 1'b1;
          end
        end
      end
      if (out_valid && !in_rng) ovf_q <= 1'b1;
      if (out_fire) oidx_q <= oidx_q + 1'b1;
    end
  end

  // PE array: kernel tap broadcast, each PE sees its own shifted image pixel.
  for (genvar gi = 0; gi < OSZ; gi++) begin : g_row
    for (genvar gj = 0; gj < OSZ; gj++) begin : g_col
      logic [PW-1:0] pidx;
      assign pidx = PW'((gi + int'(ky_q)) * IMG + gj + int'(kx_q));
      pe_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SIGNED(SIGNED)) u_pe (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (start_acc),
        .mul_en_i (mul_en),
        .acc_en_i (mac_vld_q),
        .a_i      (img_q[pidx]),
        .b_i      (ker_q[kidx]),
        .acc_o    (accs[gi*OSZ+gj])
      );
    end
  end

  // Range check and saturate/wrap of the currently selected accumulator.
  always_comb begin
    sel = accs[oidx_q];
    if (SIGNED != 0) begin
      in_rng = (&sel[ACC_W-1:OUT_W-1]) | ~(|sel[ACC_W-1:OUT_W-1]);
      satv   = sel[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end else begin
      in_rng = ~(|sel[ACC_W-1:OUT_W]);
      satv   = '1;
    end
    conv = (!in_rng && sat_q) ? satv : sel[OUT_W-1:0];
  end

  assign out_data = out_valid ? conv : '0;
  assign out_last = out_valid && (oidx_q == OW'(NRES-1));
  assign ovf      = ovf_q;
  assign done     = done_q;

endmodule

// File: tb/tb_systolic_conv_engine.sv
// Directed bench with a scoreboard queue of expected result words.
module tb_systolic_conv_engine;

  logic       clk = 1'b0;
  logic       rst, start, sat_mode, busy, ld_valid, ld_ready;
  logic [7:0] ld_data;
  logic       out_valid, out_ready, out_last, ovf, done;
  logic [7:0] out_data;

  int ncmp = 0;
  int nmis = 0;

  logic [7:0] img_v [16];
  logic [7:0] ker_v [9];
  logic [7:0] expq [$];
  bit         pre_started = 0;

  systolic_conv_engine dut (
    .clk(clk), .rst(rst), .start(start), .sat_mode(sat_mode), .busy(busy),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .ovf(ovf), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference convolution on the bench's own copy of the data.
  task automatic push_exp(input bit sat, output bit eov);
    eov = 0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        int acc = 0;
        for (int ky = 0; ky < 3; ky++)
          for (int kx = 0; kx < 3; kx++)
            acc += int'(img_v[(i+ky)*4 + j+kx]) * int'(ker_v[ky*3+kx]);
        if (acc > 255) eov = 1;
        expq.push_back((acc > 255 && sat) ? 8'd255 : acc[7:0]);
      end
  endtask

  task automatic do_load(input bit gap);
    for (int w = 0; w < 25; w++) begin
      if (gap && (w % 4 == 2)) begin
        ld_valid = 0;
        @(negedge clk);
      end
      ld_valid = 1;
      ld_data  = (w < 16) ? img_v[w] : ker_v[w-16];
      @(negedge clk);
    end
    ld_valid = 0;
  endtask

  task automatic run_job(input bit sat, input bit gap, input int stall, input bit b2b, input bit nsat);
    bit eov;
    int cyc, n, guard;
    push_exp(sat, eov);
    if (!pre_started) begin
      start = 1; sat_mode = sat;
      @(negedge clk);
      start = 0;
    end
    chk("busy_load", busy, 1);
    chk("ld_ready_load", ld_ready, 1);
    chk("ovf_cleared", ovf, 0);
    do_load(gap);
    chk("ld_ready_drop", ld_ready, 0);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      start = (cyc == 2 || cyc == 3);  // ignored while busy
      @(negedge clk);
      cyc++;
    end
    start = 0;
    chk("first_valid_latency", cyc, 10);
    n = 0; guard = 0;
    while (expq.size() > 0 && guard < 100) begin
      if (out_valid) begin
        chk("out_data", out_data, expq[0]);
        chk("out_last", out_last, (expq.size() == 1));
        if (n == stall) begin
          repeat (3) begin
            @(negedge clk);
            chk("hold_data", out_data, expq[0]);
            chk("hold_last", out_last, (expq.size() == 1));
          end
        end
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        void'(expq.pop_front());
        n++;
      end else begin
        @(negedge clk);
        guard++;
      end
    end
    chk("words_left", expq.size(), 0);
    chk("valid_drop", out_valid, 0);
    chk("done_pulse", done, 1);
    chk("busy_idle", busy, 0);
    chk("ovf_end", ovf, eov);
    if (b2b) begin
      start = 1; sat_mode = nsat;
    end
    @(negedge clk);
    start = 0;
    if (b2b) begin
      chk("b2b_busy", busy, 1);
    end else begin
      chk("done_low", done, 0);
      chk("ovf_hold", ovf, eov);
    end
    pre_started = b2b;
  endtask

  task automatic set_ramp_center();
    for (int i = 0; i < 16; i++) img_v[i] = 8'(i + 1);
    for (int i = 0; i < 9; i++)  ker_v[i] = (i == 4) ? 8'd1 : 8'd0;
  endtask

  task automatic set_fill(input logic [7:0] iv, input logic [7:0] kv);
    for (int i = 0; i < 16; i++) img_v[i] = iv;
    for (int i = 0; i < 9; i++)  ker_v[i] = kv;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ld_ready"}, ld_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_out_data"}, out_data, 0);
  endtask

  initial begin
    rst = 0; start = 0; sat_mode = 0; ld_valid = 0; ld_data = 0; out_ready = 0;
    repeat (2) @(negedge clk);
    chk_reset_outs("por");
    rst = 1;
    @(negedge clk);

    set_fill(8'd1, 8'd1);                       // 9,9,9,9
    for (int i = 0; i < 4; i++) expq.delete();
    run_job(0, 0, -1, 0, 0);

    set_ramp_center();                          // 6,7,10,11
    run_job(0, 0, -1, 1, 1);

    set_fill(8'd255, 8'd255);                   // saturate: 255 x4
    run_job(1, 0, -1, 1, 0);

    run_job(0, 0, -1, 0, 0);                    // wrap: 9 x4

    set_ramp_center();                          // gaps + output stall
    run_job(0, 1, 1, 0, 0);

    // Abandon a job mid-compute with an asynchronous reset.
    start = 1; sat_mode = 1;
    @(negedge clk);
    start = 0;
    do_load(0);
    repeat (3) @(negedge clk);
    #2 rst = 0;
    #1 chk_reset_outs("rst_mid");
    @(negedge clk);
    @(negedge clk);
    chk("rst_no_done", done, 0);
    rst = 1;
    @(negedge clk);
    chk("rst_release_idle", busy, 0);

    for (int i = 0; i < 16; i++) img_v[i] = 8'($urandom_range(0, 40));
    for (int i = 0; i < 9; i++)  ker_v[i] = 8'($urandom_range(0, 3));
    run_job(1, 1, 3, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end

endmodule

// File: doc/systolic_conv_engine.md
SYSTOLIC_CONV_ENGINE -- requirements
Module: systolic_conv_engine

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- DATA_W, 8, pixel/kernel word width
- IMG, 4, input image side length (IMG x IMG)
- K, 3, kernel side length (K x K); K <= IMG
- ACC_W, 2*DATA_W+clog2(K*K) (20), accumulator width
- OUT_W, 8, output word width
- SIGNED, 0, 1 = two's-complement operands and accumulation
REQ-002 Derived: OUT = IMG-K+1 (output side length); NOUT = OUT*OUT; NLOAD = IMG*IMG + K*K.
REQ-003 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin a job; sampled only in IDLE
- sat_mode  in  1  1 = saturate output, 0 = wrap; captured on accepted start
- busy  out  1  high in every state except IDLE
- ld_valid  in  1  load word valid
- ld_ready  out  1  high only in LOAD
- ld_data  in  DATA_W  image words row-major, then kernel words row-major
- out_valid  out  1  result word valid
- out_ready  in  1  downstream accepts result
- out_data  out  OUT_W  result word, row-major
- out_last  out  1  high with final result word (index NOUT-1)
- ovf  out  1  sticky per job: any result exceeded OUT_W range
- done  out  1  one-cycle pulse at job end

Function
REQ-004 FSM states SHALL be IDLE, LOAD, COMPUTE, OUTPUT; start accepted only in IDLE, start in any other state ignored.
REQ-005 IDLE -> LOAD on start=1; accepted start clears ovf, all accumulators and the load/step/output counters.
REQ-006 LOAD SHALL accept one word per cycle with ld_valid&&ld_ready; ld_valid gaps stall without loss; words 0..IMG*IMG-1 fill image buffer, remaining K*K fill kernel buffer.
REQ-007 LOAD -> COMPUTE on the edge accepting word NLOAD-1; ld_ready SHALL be 0 from the next cycle.
REQ-008 COMPUTE SHALL run exactly K*K steps, step s = ky*K+kx; kernel[ky][kx] broadcast to all PEs; PE(i,j) receives image[i+ky][j+kx] and accumulates the product (output-stationary).
REQ-009 COMPUTE -> OUTPUT after step K*K-1; out_valid SHALL first rise exactly K*K+1 cycles after the edge accepting the final load word.
REQ-010 Products/sums SHALL be exact in ACC_W bits, signed or unsigned per SIGNED; no intermediate rounding.
REQ-011 Output conversion: sat_mode=1 clamps to OUT_W range (unsigned 0..2^OUT_W-1; signed -2^(OUT_W-1)..2^(OUT_W-1)-1); sat_mode=0 takes low OUT_W bits; ovf set in either mode if value out of range.
REQ-012 OUTPUT SHALL present results in row-major order, advance only on out_valid&&out_ready; with out_ready=0, out_data/out_last SHALL hold stable.
REQ-013 After the handshake of the word with out_last=1: out_valid drops, done pulses one cycle in the next cycle, state -> IDLE; ovf holds until the next accepted start.
REQ-014 start=1 held in the IDLE cycle after done SHALL begin a new job with no extra idle cycle.

Reset
REQ-015 While rst=0 (asynchronous): state=IDLE; busy, ld_ready, out_valid, out_last, ovf, done = 0; out_data = 0; all accumulators, buffers and counters = 0.
REQ-016 Reset asserted mid-job SHALL abandon the job; no done pulse; first job after release behaves identically to power-up.

Structure
REQ-017 A shared package conv_pkg SHALL hold the state enum and the derived constants (OUT, NOUT, NLOAD, counter widths).
REQ-018 Each array element SHALL be one sub-module pe_mac (multiply-accumulate, clear, enable), instantiated OUT x OUT times via generate.

Verification
REQ-019 IMG=4, K=3, all-ones image and kernel -> outputs 9,9,9,9; out_last on 4th; done one cycle later.
REQ-020 Image 1..16 row-major, kernel center=1 others 0 -> outputs 6,7,10,11; ovf=0.
REQ-021 Image all 255, kernel all 255 (acc 585225): sat_mode=1 -> 255 x4, ovf=1; sat_mode=0 -> 9 x4, ovf=1.
REQ-022 out_ready low 3 cycles while word 1 presented -> word 1 held stable, sequence 6,7,10,11 intact; ld_valid gaps during LOAD -> same results.
REQ-023 rst low during COMPUTE -> all outputs 0 immediately, no done; start during busy ignored; subsequent job yields correct results.
